seven_segment_scanner: RTL
==========================

Name: seven_segment_scanner

Overview:
Parametrised successor to the single-display alternating driver. Accepts a binary value via a load handshake and converts it to BCD with a sequential double-dabble engine. Time-multiplexes NUM_DIGITS common-select 7-segment digits from one shared segment bus. Sits between the switch/datapath logic and the board display pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8); BCD width = 4*NUM_DIGITS
BIN_WIDTH, 14, width of the binary input (1..27)
REFRESH_DIV, 50000, clk cycles each digit stays selected (>=2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
value_in  input  BIN_WIDTH  unsigned binary value to display
load  input  1  single-cycle request; sampled only when busy=0
busy  output  1  high while a conversion is in progress
overflow  output  1  last committed value exceeded 10^NUM_DIGITS-1
segment  output  7  segment drive, bit0=a..bit6=g, active-high
digit_en  output  NUM_DIGITS  one-hot digit select; bit0 = least-significant digit

Behaviour:
- Reset (async assert, sync release): segment=7'b0111111 (digit 0 shows "0"), digit_en=1, busy=0, overflow=0, committed BCD=0, scan counter=0, digit index=0, FSM=IDLE.
- FSM states: IDLE, CONVERT, COMMIT.
- IDLE: load=1 captures value_in into the shift register, clears working BCD and the overflow flag, and moves to CONVERT. busy goes high the next cycle.
- CONVERT: exactly BIN_WIDTH cycles. Each cycle, every BCD nibble >=5 gets +3, then {BCD,bin} shifts left by one.
- Working overflow flag sets if a 1 shifts out of the top BCD bit on any step.
- After the last step, move to COMMIT.
- COMMIT: one cycle. Copies working BCD into the display registers, updates overflow, returns to IDLE. busy drops the cycle after COMMIT.
- Latency: committed digits and overflow are visible BIN_WIDTH+2 cycles after the load-sampling edge.
- load while busy=1: ignored, no queueing.
- load in the same cycle busy falls: ignored. Only a load seen with busy=0 at the clock edge is accepted.
- Scan: counter runs 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index increments modulo NUM_DIGITS. NUM_DIGITS-1 wraps to 0.
- Scanning never stops, including during conversion. The display holds the previous committed value until COMMIT.
- digit_en = one-hot of the digit index, registered.
- segment is registered and aligned with digit_en in the same cycle; no ghosting cycle.
- Decode: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111. Nibbles >9 are unreachable and decode to 0000000.
- Overflow: when committed overflow=1, every digit shows a dash (segment=7'b1000000). This overrides blanking.
- Value 0: all digits show "0", or only digit 0 when the optional feature is compiled in.
- rst asserted mid-CONVERT aborts the conversion. All state returns to reset values and nothing partial is committed.

Optional Feature:
SEVEN_SEG_LEADING_ZERO_BLANK_EN
- Defined: any digit above the most-significant nonzero committed digit drives segment=0000000 while selected. Digit 0 is never blanked. digit_en scanning is unchanged.
- Undefined: all digits display their value, including leading zeros.
- The blank mask is computed at COMMIT and registered alongside the digits.

Test Plan:
- NUM_DIGITS=4, BIN_WIDTH=14, REFRESH_DIV=4; reset released -> digit_en steps 0001,0010,0100,1000,0001, each for 4 cycles; segment=0111111 on every digit; busy=0, overflow=0.
- Load 1234 -> busy=1 for 15 cycles. Display updates at cycle 16 after load: digit_en=0001 shows 1100110 ("4"), 0010 shows 1001111 ("3"), 0100 shows 1011011 ("2"), 1000 shows 0000110 ("1").
- Load 10000 -> overflow=1 after commit; every digit shows 1000000. Then load 9999 -> overflow=0 and all digits show 1101111.
- Load 42, then pulse load=1 with value 7 at cycles 3 and 15 of the conversion -> both ignored; display commits 0042.
- Load 5678, assert rst at conversion cycle 6 -> busy=0, display reverts to all "0", overflow=0; a later load of 5678 converts correctly.
- With SEVEN_SEG_LEADING_ZERO_BLANK_EN, load 7 -> digits 3..1 drive 0000000 and digit 0 shows 0000111. Load 0 -> digit 0 shows 0111111, other digits blank.

Source files
------------

// File: rtl/seven_segment_scanner.sv
// Multiplexed 7-segment driver with sequential double-dabble BCD conversion.
// Optional leading-zero blanking: define SEVEN_SEG_LEADING_ZERO_BLANK_EN.
module seven_segment_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int BIN_WIDTH   = 14,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BIN_WIDTH-1:0]  value_in,
    input  logic                  load,
    output logic                  busy,
    output logic                  overflow,
    output logic [6:0]            segment,
    output logic [NUM_DIGITS-1:0] digit_en
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int STEP_W = $clog2(BIN_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    state_t                state;
    logic [BIN_WIDTH-1:0]  shift_reg;
    logic [BCD_W-1:0]      work_bcd;
    logic [BCD_W-1:0]      adj_bcd;
    logic [BCD_W-1:0]      disp_bcd;
    logic                  work_ovf;
    logic [STEP_W-1:0]     step;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic [NUM_DIGITS-1:0] disp_blank;

    logic [CNT_W-1:0]      scan_cnt;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic                  scan_tc;
    logic [3:0]            sel_nib;
    logic                  sel_blank;
    logic [6:0]            seg_next;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'b0111111;
            4'd1:    decode = 7'b0000110;
            4'd2:    decode = 7'b1011011;
            4'd3:    decode = 7'b1001111;
            4'd4:    decode = 7'b1100110;
            4'd5:    decode = 7'b1101101;
            4'd6:    decode = 7'b1111101;
            4'd7:    decode = 7'b0000111;
            4'd8:    decode = 7'b1111111;
            4'd9:    decode = 7'b1101111;
            default: decode = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        adj_bcd = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (work_bcd[4*i +: 4] >= 4'd5)
                adj_bcd[4*i +: 4] = work_bcd[4*i +: 4] + 4'd3;
            else
                adj_bcd[4*i +: 4] = work_bcd[4*i +: 4];
        end
    end

    // Mask is taken from the finished working BCD, which is stable during COMMIT
    always_comb begin
        blank_mask = '0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        begin
            logic        higher_zero;
            int unsigned j;
            higher_zero = 1'b1;
            for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
                j = NUM_DIGITS - 1 - i;
                higher_zero = higher_zero && (work_bcd[4*j +: 4] == 4'd0);
                blank_mask[j] = higher_zero;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shift_reg  <= '0;
            work_bcd   <= '0;
            work_ovf   <= 1'b0;
            step       <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            disp_bcd   <= '0;
            disp_blank <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shift_reg <= value_in;
                        work_bcd  <= '0;
                        work_ovf  <= 1'b0;
                        step      <= '0;
                        busy      <= 1'b1;
                        state     <= CONVERT;
                    end
                end
                CONVERT: begin
                    work_bcd  <= {adj_bcd[BCD_W-2:0], shift_reg[BIN_WIDTH-1]};
                    shift_reg <= shift_reg << 1;
                    if (adj_bcd[BCD_W-1])
                        work_ovf <= 1'b1;
                    if (step == STEP_W'(BIN_WIDTH - 1))
                        state <= COMMIT;
                    else
                        step <= step + 1'b1;
                end
                COMMIT: begin
                    disp_bcd   <= work_bcd;
                    disp_blank <= blank_mask;
                    overflow   <= work_ovf;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        scan_tc  = (scan_cnt == CNT_W'(REFRESH_DIV - 1));
        idx_next = idx;
        if (scan_tc)
            idx_next = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
    end

    // Segment is decoded from the upcoming index so it lands with digit_en
    always_comb begin
        sel_nib   = '0;
        sel_blank = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (IDX_W'(i) == idx_next) begin
                sel_nib   = disp_bcd[4*i +: 4];
                sel_blank = disp_blank[i];
            end
        end
        if (overflow)
            seg_next = 7'b1000000;
        else if (sel_blank)
            seg_next = 7'b0000000;
        else
            seg_next = decode(sel_nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            digit_en <= NUM_DIGITS'(1);
            segment  <= 7'b0111111;
        end else begin
            scan_cnt <= scan_tc ? '0 : scan_cnt + 1'b1;
            idx      <= idx_next;
            digit_en <= NUM_DIGITS'(1) << idx_next;
            segment  <= seg_next;
        end
    end

endmodule
